countdown_counter: RTL and testbench

Loadable down-counter with a start/ready handshake. When idle it advertises `ready`. A `start` request loads the terminal value and counts down to zero, one step per clock. It then returns to idle. It serves as a simple programmable-delay or countdown timer inside a larger control path.

---
 rtl/countdown_pkg.sv | 16 +
 rtl/rst_sync.sv | 20 ++
 rtl/countdown_counter.sv | 63 ++++++
 tb/tb_countdown_counter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 5;

  // Largest value representable in the given width.
  function automatic int default_load(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after two clock edges.
module rst_sync (
  input  logic clk,
  input  logic rst,
  output logic rst_clean
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  assign rst_clean = sync[1];

endmodule

// File: rtl/countdown_counter.sv
// Down-counter with start/ready handshake: loads LOAD_VALUE on start and counts to zero.
module countdown_counter
  import countdown_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOAD_VALUE = default_load(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] LOAD_Q = LOAD_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             rst_clean;
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_nxt;

  rst_sync u_rst_sync (
    .clk       (clk),
    .rst       (rst),
    .rst_clean (rst_clean)
  );

  always_ff @(posedge clk or negedge rst_clean) begin
    if (!rst_clean) begin
      state <= IDLE;
      q     <= '0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    case (state)
      IDLE: begin
        if (start) begin
          q_nxt     = LOAD_Q;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        // Zero is the floor; the edge that sees zero only returns to idle.
        if (q != '0) begin
          q_nxt = q - ONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

endmodule

// File: tb/tb_countdown_counter.sv
// Bench for countdown_counter: default and small-width instances against a timeline model.
module tb_countdown_counter;

  localparam int LOAD0 = 31;
  localparam int LOAD3 = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start3;
  logic       ready;
  logic [4:0] q;
  logic       ready3;
  logic [2:0] q3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc0     = -1;
  int acc3     = -1;
  int rel_edges = 0;

  always #5 clk = ~clk;

  countdown_counter u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ready (ready),
    .q     (q)
  );

  countdown_counter #(.WIDTH(3), .LOAD_VALUE(LOAD3)) u_dut3 (
    .clk   (clk),
    .rst   (rst),
    .start (start3),
    .ready (ready3),
    .q     (q3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Model: a countdown accepted at cycle acc is busy for load+1 cycles,
  // showing load-(elapsed) until it reaches zero; idle shows q=0, ready=1.
  function automatic bit m_busy(input int acc, input int load, input int c);
    return (acc >= 0) && ((c - acc) <= load);
  endfunction

  function automatic int m_q(input int acc, input int load, input int c);
    return m_busy(acc, load, c) ? (load - (c - acc)) : 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_q"},      int'(q),      m_q(acc0, LOAD0, cyc));
    check({tag, "_ready"},  int'(ready),  m_busy(acc0, LOAD0, cyc) ? 0 : 1);
    check({tag, "_q3"},     int'(q3),     m_q(acc3, LOAD3, cyc));
    check({tag, "_ready3"}, int'(ready3), m_busy(acc3, LOAD3, cyc) ? 0 : 1);
  endtask

  task automatic step(input logic s, input logic s3, input string tag);
    start  = s;
    start3 = s3;
    @(posedge clk);
    cyc++;
    rel_edges++;
    if (rel_edges >= 3) begin
      if (s && !m_busy(acc0, LOAD0, cyc - 1)) acc0 = cyc;
      if (s3 && !m_busy(acc3, LOAD3, cyc - 1)) acc3 = cyc;
    end
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    #6;
    check("reset_q",      int'(q),      0);
    check("reset_ready",  int'(ready),  1);
    check("reset_q3",     int'(q3),     0);
    check("reset_ready3", int'(ready3), 1);
    #1 rst = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "idle_hold");

    // Single countdown on both instances
    step(1'b1, 1'b1, "single_accept");
    check("single_load", int'(q), LOAD0);
    check("single_load3", int'(q3), LOAD3);
    for (int i = 0; i < 33; i++) step(1'b0, 1'b0, "single_run");

    // Held start: back-to-back countdowns
    for (int i = 0; i < 70; i++) step(1'b1, 1'b0, "held");
    for (int i = 0; i < 34; i++) step(1'b0, 1'b0, "held_drain");

    // Start while counting must be ignored
    step(1'b1, 1'b0, "busy_accept");
    for (int i = 0; i < 40 && m_q(acc0, LOAD0, cyc) != 15; i++) step(1'b0, 1'b0, "busy_run");
    check("busy_at15", int'(q), 15);
    step(1'b1, 1'b0, "busy_poke");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "busy_cont");

    // Asynchronous reset in the middle of a countdown
    step(1'b1, 1'b1, "mid_accept");
    for (int i = 0; i < 40 && m_q(acc0, LOAD0, cyc) != 20; i++) step(1'b0, 1'b0, "mid_run");
    check("mid_at20", int'(q), 20);
    #2 rst = 1'b0;
    #1;
    acc0 = -1;
    acc3 = -1;
    check("async_q",      int'(q),      0);
    check("async_ready",  int'(ready),  1);
    check("async_q3",     int'(q3),     0);
    check("async_ready3", int'(ready3), 1);
    #3 rst = 1'b1;
    rel_edges = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "post_reset_idle");

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
